// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared FSM state type and default detector pattern
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;
  localparam int DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;
endpackage

// File: rtl/serial_pattern_det.sv
// serial_pattern_det: overlapping Mealy detector over a serial bit stream
module serial_pattern_det
  import seq_scan_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic det
);
  localparam int FW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-2:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic [PAT_LEN-1:0] w_win;
  assign w_win = {r_hist, bit_in};
  assign det = en && (r_fill == FW'(PAT_LEN - 1)) && (w_win == PATTERN);
  // history shifts every enabled bit; fill saturates once a full window of history exists
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_win[PAT_LEN-2:0];
      r_fill <= (r_fill == FW'(PAT_LEN - 1)) ? r_fill : r_fill + 1'b1;
    end
  end
endmodule

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin sharing of one serial pattern detector between requesters
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W = 8,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int IDW = 1,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_hit,
  output logic              det,
  output logic              busy
);
  state_t           r_state, w_next;
  logic [IDW-1:0]   r_ptr, r_id, w_gnt;
  logic [W-1:0]     r_shreg;
  logic [CNT_W-1:0] r_cnt, r_bitcnt;
  logic             w_gnt_vld, w_xfer, w_det, w_last;
  logic [W-1:0]     w_words [NREQ];
  int               w_best;
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign w_words[g] = req_data[g*W +: W];
  end
  // pick the valid requester nearest to the round-robin pointer
  always_comb begin
    w_gnt = '0;
    w_gnt_vld = 1'b0;
    w_best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && ((i + NREQ - int'(r_ptr)) % NREQ) < w_best) begin
        w_best = (i + NREQ - int'(r_ptr)) % NREQ;
        w_gnt = IDW'(i);
        w_gnt_vld = 1'b1;
      end
    end
  end
  assign w_last = r_bitcnt == CNT_W'(W - 1);
  // next state and handshake outputs
  always_comb begin
    w_xfer = r_state == IDLE && w_gnt_vld && !rst;
    req_ready = w_xfer ? NREQ'(1) << w_gnt : '0;
    res_valid = r_state == RESULT;
    busy = r_state != IDLE;
    w_next = (r_state == IDLE && w_gnt_vld) ? SCAN :
             (r_state == SCAN && w_last) ? RESULT :
             (r_state == RESULT && res_ready) ? IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // word capture, serialisation and match counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id <= '0;
      r_shreg <= '0;
      r_cnt <= '0;
      r_bitcnt <= '0;
    end else if (w_xfer) begin
      r_shreg <= w_words[w_gnt];
      r_id <= w_gnt;
      r_cnt <= '0;
      r_bitcnt <= '0;
      r_ptr <= IDW'((int'(w_gnt) + 1) % NREQ);
    end else if (r_state == SCAN) begin
      r_shreg <= {r_shreg[W-2:0], 1'b0};
      r_bitcnt <= r_bitcnt + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_det);
    end
  end
  serial_pattern_det #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_det (
    .clk(clk), .rst(rst), .clr(w_xfer), .en(r_state == SCAN),
    .bit_in(r_shreg[W-1]), .det(w_det)
  );
  assign det = w_det;
  assign res_id = r_id;
  assign res_count = r_cnt;
  assign res_hit = |r_cnt;
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// tb_seq_scan_arbiter: directed vector and corner-case checks of the shared scan arbiter
module tb_seq_scan_arbiter;
  logic clk = 0, rst = 1, res_ready = 1, res_valid, res_hit, det, busy;
  logic [1:0] req_valid = '0, req_ready;
  logic [15:0] req_data = '0;
  logic res_id;
  logic [3:0] res_count;
  int n_tests = 0, n_fail = 0;
  typedef struct { int id; logic [7:0] data; logic [7:0] mask; logic [3:0] cnt; } vec_t;
  vec_t vecs [8];
  always #5 clk = ~clk;
  seq_scan_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count),
    .res_hit(res_hit), .det(det), .busy(busy)
  );
  task automatic tick; @(posedge clk); #1; endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_word(input int id, input logic [7:0] d, input logic [7:0] m, input logic [3:0] c);
    req_data[id*8 +: 8] = d;
    req_valid = 2'(1 << id);
    #1;
    chk("grant", 32'(req_ready), 32'(1 << id));
    tick;
    req_valid = '0;
    #1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("det_bit%0d", k), 32'(det), 32'(m[8-k]));
      chk("busy_scan", 32'(busy), 1);
      chk("ready_scan", 32'(req_ready), 0);
      tick;
    end
    chk("res_valid", 32'(res_valid), 1);
    chk("res_id", 32'(res_id), 32'(id));
    chk("res_count", 32'(res_count), 32'(c));
    chk("res_hit", 32'(res_hit), 32'(c != 0));
    chk("det_result", 32'(det), 0);
    tick;
    chk("res_valid_done", 32'(res_valid), 0);
  endtask
  initial begin
    vecs[0] = '{0, 8'b1101_0000, 8'b0001_0000, 4'd1};
    vecs[1] = '{0, 8'b1101_1010, 8'b0001_0010, 4'd2};
    vecs[2] = '{0, 8'b0000_0110, 8'b0000_0000, 4'd0};
    vecs[3] = '{0, 8'b1000_0000, 8'b0000_0000, 4'd0};
    vecs[4] = '{1, 8'b1101_1101, 8'b0001_0001, 4'd2};
    vecs[5] = '{1, 8'b1011_0110, 8'b0000_0100, 4'd1};
    vecs[6] = '{0, 8'b1111_1111, 8'b0000_0000, 4'd0};
    vecs[7] = '{1, 8'b1101_1011, 8'b0001_0010, 4'd2};
    rst = 1; req_valid = 2'b11; req_data = 16'hFFFF; res_ready = 1;
    tick; tick;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_count", 32'(res_count), 0);
    chk("rst_hit", 32'(res_hit), 0);
    chk("rst_det", 32'(det), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0; req_valid = 2'b01;
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    req_valid = '0;
    tick;
    for (int v = 0; v < 8; v++) run_word(vecs[v].id, vecs[v].data, vecs[v].mask, vecs[v].cnt);
    rst = 1; req_valid = '0;
    tick; tick;
    rst = 0; req_data = {8'b1101_1010, 8'b1101_0000}; req_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % 2)));
      tick;
      repeat (8) tick;
      chk("rr_res_valid", 32'(res_valid), 1);
      chk("rr_res_id", 32'(res_id), 32'(g % 2));
      chk("rr_res_count", 32'(res_count), (g % 2) ? 2 : 1);
      tick;
    end
    res_ready = 0;
    #1;
    chk("bp_grant", 32'(req_ready), 1);
    tick;
    repeat (8) tick;
    for (int s = 0; s < 3; s++) begin
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_res_id", 32'(res_id), 0);
      chk("bp_res_count", 32'(res_count), 1);
      chk("bp_res_hit", 32'(res_hit), 1);
      chk("bp_ready", 32'(req_ready), 0);
      tick;
    end
    res_ready = 1;
    #1;
    chk("bp_still_valid", 32'(res_valid), 1);
    tick;
    chk("bp_taken", 32'(res_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 2);
    req_valid = '0;
    rst = 1; tick; rst = 0; tick;
    req_data = {8'b1101_0000, 8'b1101_0000}; req_valid = 2'b01;
    #1;
    chk("mr_grant", 32'(req_ready), 1);
    tick;
    req_valid = 2'b11;
    tick; tick;
    chk("mr_busy_bit3", 32'(busy), 1);
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_res_valid", 32'(res_valid), 0);
    chk("mr_grant_after", 32'(req_ready), 1);
    req_valid = '0;
    for (int s = 0; s < 12; s++) begin
      chk("mr_no_result", 32'(res_valid), 0);
      tick;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
